// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package if_fetch_pkg;

    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam inst_addr_t RESET_PC_DEFAULT = 32'h0000_0000;
    localparam inst_addr_t PC_STEP          = 32'd4;

    // Fetch FSM encoding.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    // One presented (or buffered) instruction; all-zero is a bubble.
    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
    } fetch_pkt_t;

    localparam fetch_pkt_t BUBBLE = '0;

    // Fetch addresses are always word aligned.
    function automatic inst_addr_t word_align(input inst_addr_t a);
        return a & ~inst_addr_t'(3);
    endfunction

endpackage

// File: rtl/if_fetch_pc_reg.sv
// Program counter: next word address to fetch, with redirect load and +4 step.
// Latency: load/increment visible on pc_o the cycle after the request.
// Backpressure: none; the fetch FSM decides when to step or load.
// Ports: clk/rst (async, active high), load_i + load_addr_i (redirect),
//        inc_i (advance by one word), pc_o (current fetch address).
module if_fetch_pc_reg
    import if_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_i,
    input  logic [INST_ADDR_W-1:0] load_addr_i,
    input  logic                   inc_i,
    output logic [INST_ADDR_W-1:0] pc_o
);

    inst_addr_t pc_q;
    inst_addr_t pc_d;

    // A redirect wins over a step taken in the same cycle.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = word_align(load_addr_i);
        end else if (inc_i) begin
            pc_d = pc_q + PC_STEP;   // wraps modulo 2^32
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= word_align(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, fetches words over req/ack, presents one instruction or bubble per cycle.
// Latency: instruction acked in cycle N appears on if_pc/if_inst in N+1; one per cycle with zero-wait memory.
// Backpressure: stall during an ack parks the word in a one-entry buffer and pauses fetching until stall falls.
// Ports: clk, rst (async, active high); br/br_addr redirect; stall from downstream;
//        mem_req/mem_addr/mem_ack/mem_rdata memory handshake; if_pc/if_inst to the IF/ID register.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter inst_addr_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   br,
    input  logic [INST_ADDR_W-1:0] br_addr,
    input  logic                   stall,
    output logic                   mem_req,
    output logic [INST_ADDR_W-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [INST_W-1:0]      mem_rdata,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst
);

    fetch_state_e state_q;
    fetch_pkt_t   out_q;
    fetch_pkt_t   buf_q;
    inst_addr_t   drop_addr_q;   // address of the wrong-path fetch still awaiting its ack
    inst_addr_t   pc;
    fetch_pkt_t   fetched;
    logic         pc_inc;

    // Every redirect reloads the PC; only a kept transfer advances it.
    assign pc_inc = (state_q == S_REQ) && mem_ack && !br;

    if_fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst         (rst),
        .load_i      (br),
        .load_addr_i (br_addr),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    assign fetched.pc   = pc;
    assign fetched.inst = mem_rdata;

    // The request decodes straight from the state register so reset drops it immediately.
    // In DROP the old address must stay on the bus even though pc already holds the target.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        case (state_q)
            S_REQ: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end
            S_DROP: begin
                mem_req  = 1'b1;
                mem_addr = drop_addr_q;
            end
            default: begin
                mem_req  = 1'b0;
                mem_addr = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_q       <= BUBBLE;
            buf_q       <= BUBBLE;
            drop_addr_q <= '0;
        end else begin
            // IF/ID captures every cycle, so anything not explicitly loaded is a bubble.
            out_q <= BUBBLE;
            if (br) begin
                buf_q <= BUBBLE;
            end
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (br) begin
                        // A same-cycle ack is wrong-path data; without one the stale
                        // request is still in flight and must be drained first.
                        if (!mem_ack) begin
                            state_q     <= S_DROP;
                            drop_addr_q <= pc;
                        end
                    end else if (mem_ack) begin
                        if (stall) begin
                            buf_q   <= fetched;
                            state_q <= S_HOLD;
                        end else begin
                            out_q <= fetched;
                        end
                    end
                end
                S_HOLD: begin
                    if (br) begin
                        state_q <= S_REQ;
                    end else if (!stall) begin
                        out_q   <= buf_q;
                        buf_q   <= BUBBLE;
                        state_q <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (mem_ack) begin
                        state_q <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_pc   = out_q.pc;
    assign if_inst = out_q.inst;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed timing scenarios followed by randomized traffic.
// The memory answers addr ^ A5A5_0000; a scoreboard tracks the expected program-order PC stream.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SIG      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        br = 1'b0;
    logic [31:0] br_addr = '0;
    logic        stall = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .br        (br),
        .br_addr   (br_addr),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .if_pc     (if_pc),
        .if_inst   (if_inst)
    );

    int n_vec = 0;
    int n_err = 0;

    // memory model state
    int          lat_fixed = 0;   // <0 selects a random 0..3 wait per fetch
    int          lat_cur   = 0;
    int          wcnt      = 0;
    bit          pending   = 1'b0;
    // previous-cycle observations
    logic        prev_req   = 1'b0;
    logic        prev_ack   = 1'b0;
    logic        prev_br    = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;
    // reference: next PC expected to be presented in program order
    logic [31:0] exp_pc = RESET_PC;
    int          gap = 0;
    bit          rand_phase = 1'b0;

    bit          found;
    bit          seen;
    int          last;
    int          n_pres;
    logic        rb;
    logic        rs;
    logic [31:0] rba;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge and apply the always-true rules.
    task automatic tick();
        @(negedge clk);
        chk("addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
        if (prev_req && !prev_ack) begin
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("addr_hold", mem_addr, prev_addr);
        end
        if (if_inst != 32'd0) begin
            chk("pc_order", if_pc, exp_pc);
            chk("inst_data", if_inst, if_pc ^ SIG);
            chk("present_blocked", {30'd0, prev_br, prev_stall}, 32'd0);
            exp_pc = if_pc + 32'd4;
            gap = 0;
        end else begin
            chk("bubble_pc", if_pc, 32'd0);
            gap++;
        end
        if (rand_phase) begin
            chk("progress", 32'(gap > 60), 32'd0);
        end
    endtask

    // Drive this cycle's inputs, including the memory's answer to the current request.
    task automatic drive(input logic b, input logic [31:0] ba, input logic s);
        br      = b;
        br_addr = ba;
        stall   = s;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (!pending) begin
                pending = 1'b1;
                wcnt    = 0;
                lat_cur = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            end
            if (wcnt >= lat_cur) begin
                mem_ack = 1'b1;
                pending = 1'b0;
            end else begin
                wcnt++;
            end
        end else begin
            pending = 1'b0;
        end
        mem_rdata = mem_ack ? (mem_addr ^ SIG) : $urandom;
        if (b) begin
            exp_pc = ba & ~32'h3;
        end
        prev_req   = mem_req;
        prev_ack   = mem_ack;
        prev_addr  = mem_addr;
        prev_br    = b;
        prev_stall = s;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        br         = 1'b0;
        stall      = 1'b0;
        mem_ack    = 1'b0;
        br_addr    = '0;
        mem_rdata  = '0;
        pending    = 1'b0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_br    = 1'b0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        exp_pc     = RESET_PC;
        gap        = 0;
        repeat (2) @(negedge clk);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_no_req", 32'(mem_req), 32'd0);
        drive(1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // zero-wait streaming from reset
        lat_fixed = 0;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 0) begin
                chk("first_req", 32'(mem_req), 32'd1);
                chk("first_addr", mem_addr, RESET_PC);
            end else begin
                chk("stream_pc", if_pc, RESET_PC + 32'(4 * (k - 1)));
                chk("stream_inst", if_inst, (RESET_PC + 32'(4 * (k - 1))) ^ SIG);
            end
            drive(1'b0, 32'd0, 1'b0);
        end

        // three wait cycles per fetch: one instruction every fourth cycle
        lat_fixed = 3;
        seen      = 1'b0;
        last      = 0;
        n_pres    = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (if_inst != 32'd0) begin
                if (seen) chk("wait_gap", 32'(i - last), 32'd4);
                seen = 1'b1;
                last = i;
                n_pres++;
            end
            drive(1'b0, 32'd0, 1'b0);
        end
        chk("wait_count", 32'(n_pres), 32'd5);

        // redirect with a same-cycle ack at PC 8
        lat_fixed = 0;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (mem_req && mem_addr == 32'h8) found = 1'b1;
            else drive(1'b0, 32'd0, 1'b0);
        end
        chk("br_at_pc8", 32'(found), 32'd1);
        drive(1'b1, 32'h0000_0103, 1'b0);
        chk("br_same_ack", 32'(mem_ack), 32'd1);
        tick();
        chk("br_bubble", if_inst, 32'd0);
        chk("br_fetch_addr", mem_addr, 32'h100);
        chk("br_fetch_req", 32'(mem_req), 32'd1);
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("br_target_pc", if_pc, 32'h100);
        chk("br_target_inst", if_inst, 32'h100 ^ SIG);
        drive(1'b0, 32'd0, 1'b0);

        // redirect while the fetch of 0x20 is outstanding
        tick();
        drive(1'b1, 32'h20, 1'b0);
        lat_fixed = 2;
        tick();
        chk("drop_setup_addr", mem_addr, 32'h20);
        drive(1'b1, 32'h40, 1'b0);
        chk("drop_no_ack", 32'(mem_ack), 32'd0);
        tick();
        chk("drop_stale_addr", mem_addr, 32'h20);
        chk("drop_req", 32'(mem_req), 32'd1);
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("drop_still_stale", mem_addr, 32'h20);
        drive(1'b0, 32'd0, 1'b0);
        chk("drop_stale_ack", 32'(mem_ack), 32'd1);
        tick();
        chk("drop_target_addr", mem_addr, 32'h40);
        chk("drop_discard", if_inst, 32'd0);
        lat_fixed = 0;
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("drop_target_pc", if_pc, 32'h40);
        drive(1'b0, 32'd0, 1'b0);

        // stall for four cycles starting on the ack of 0x10
        tick();
        drive(1'b1, 32'h10, 1'b0);
        tick();
        chk("stall_fetch_addr", mem_addr, 32'h10);
        drive(1'b0, 32'd0, 1'b1);
        chk("stall_ack", 32'(mem_ack), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_bubble_inst", if_inst, 32'd0);
            chk("hold_bubble_pc", if_pc, 32'd0);
            chk("hold_no_req", 32'(mem_req), 32'd0);
            drive(1'b0, 32'd0, (i < 3));
        end
        tick();
        chk("hold_release_pc", if_pc, 32'h10);
        chk("hold_release_inst", if_inst, 32'h10 ^ SIG);
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("after_hold_pc", if_pc, 32'h14);
        drive(1'b0, 32'd0, 1'b0);

        // PC wrap at the top of the address space
        tick();
        drive(1'b1, 32'hFFFF_FFFC, 1'b0);
        tick();
        chk("wrap_fetch_addr", mem_addr, 32'hFFFF_FFFC);
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("wrap_next_addr", mem_addr, 32'd0);
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        drive(1'b0, 32'd0, 1'b0);
        tick();
        chk("wrap_zero_pc_inst", if_inst, SIG);
        drive(1'b0, 32'd0, 1'b0);
        lat_fixed = 3;
        tick();
        chk("prerst_pc", if_pc, 32'h4);
        drive(1'b0, 32'd0, 1'b0);
        chk("prerst_waiting", 32'(mem_req && !mem_ack), 32'd1);

        // asynchronous reset in the middle of a request
        #1;
        rst = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'd0);
        chk("arst_if_pc", if_pc, 32'd0);
        chk("arst_if_inst", if_inst, 32'd0);
        do_reset();

        // randomized traffic against the scoreboard
        lat_fixed  = -1;
        do_reset();
        rand_phase = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            tick();
            rb = ($urandom_range(0, 11) == 0);
            rs = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) rba = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else rba = $urandom_range(0, 32'h3FFF);
            drive(rb, rba, rs);
        end
        rand_phase = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction fetch stage for the in-order RISC-V pipeline. It owns the program counter, issues word fetches to instruction memory over a req/ack handshake, and presents one instruction (or a bubble) per cycle on `if_pc`/`if_inst` for capture by the IF/ID pipeline register. It reacts to the branch redirect `br`/`br_addr` from the later stages, discards wrong-path fetches, and absorbs downstream stalls in a one-entry buffer.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `br` in 1: redirect; wrong-path instructions are discarded and fetching restarts at `br_addr`.
- `br_addr` in 32 (`InstAddrBus`): redirect target. Bits [1:0] are ignored and forced to 0.
- `stall` in 1: downstream cannot accept a new instruction this cycle.
- `mem_req` out 1: fetch request valid.
- `mem_addr` out 32: word-aligned fetch address, bits [1:0] always 0.
- `mem_ack` in 1: request accepted and `mem_rdata` is valid in this cycle. It may assert in the same cycle as `mem_req`.
- `mem_rdata` in 32 (`InstBus`): fetched instruction word.
- `if_pc` out 32: PC of the presented instruction. It is 0 for a bubble.
- `if_inst` out 32: presented instruction. It is 0 for a bubble, and 0 is treated as a NOP.

## Operation
- The handshake transfer happens in a cycle where `mem_req && mem_ack`.
- While `mem_req` is high without an ack, `mem_addr` holds stable and `mem_req` does not drop.
- The `pc` register holds the next address to fetch. After each accepted (non-discarded) transfer, `pc` becomes `pc+4`, wrapping modulo 2^32.
- A one-entry buffer (`buf_pc`, `buf_inst`) holds an instruction fetched while `stall` is high.

**States**
- IDLE
  - Entered on reset.
  - `mem_req` = 0.
  - Goes to REQ on the next edge, unless `br` is high: then `pc <= br_addr` and it still goes to REQ.
- REQ
  - `mem_req` = 1, `mem_addr` = `pc`.
  - Ack with `!br && !stall`: outputs take `{pc, mem_rdata}` and the state stays REQ.
  - Ack with `!br && stall`: the buffer takes `{pc, mem_rdata}` and the state moves to HOLD.
  - Either ack case also does `pc <= pc+4`.
  - No ack: stay in REQ.
- HOLD
  - `mem_req` = 0 and the output is a bubble.
  - When `stall` falls: outputs take the buffer contents and the state moves to REQ.
- DROP
  - `mem_req` = 1, `mem_addr` = the stale address, held until ack.
  - On ack: the data is discarded and the state moves to REQ at the redirect target already loaded in `pc`.

**Redirect (`br`)**
- `br` has priority over `stall` and over any ack in the same cycle.
- `pc <= br_addr`, the buffer is cleared, and the outputs load a bubble on that edge.
- Per state:
  - In REQ with no ack: go to DROP.
  - In REQ with a same-cycle ack: the data is discarded and the state goes directly to REQ.
  - In HOLD: go to REQ.
  - In DROP: the target is updated and the state stays DROP. An ack in that same cycle goes to REQ.

**Outputs**
- Any cycle that does not load an instruction loads a bubble into `if_pc`/`if_inst` (both 0).
- Stalled cycles never re-present the same instruction, because the IF/ID register captures every cycle.

## Timing
- Reset values:
  - Outputs: `if_pc` = 0, `if_inst` = 0, `mem_req` = 0, `mem_addr` = 0.
  - Internal state: `pc` = `RESET_PC`, state = IDLE, buffer = 0.
- `mem_req` first rises in the second cycle after `rst` falls.
- `if_*` are registered: an instruction acked in cycle N appears in cycle N+1.
- With zero-wait memory (ack tied high), throughput is one instruction per cycle.
- Redirect latency with zero-wait memory: `br` in cycle N, fetch of `br_addr` in N+1, target instruction on `if_*` in N+2.
- Redirect latency with a k-cycle outstanding fetch: the stale ack is awaited first, then the target is fetched.
- Reset asserted mid-request drops `mem_req` immediately (asynchronously). No ack is expected afterwards, and memory must abandon the request.
- A `stall` that rises in the same cycle as an ack is captured in the buffer, not lost.

## Structure
- `InstAddrBus`, `InstBus`, the default reset PC and the state encodings (2-bit IDLE/REQ/HOLD/DROP) are added to the shared `defines.v`.
- One natural sub-module, `pc_reg`: the PC register with reset, increment and redirect load. The FSM, buffer and output registers stay in `if_fetch`.

## Test plan
- Reset, then zero-wait memory returning `mem_rdata = addr ^ 32'hA5A5_0000` -> `if_pc` = 0, 4, 8, … on consecutive cycles, each with the matching `if_inst`.
- Ack delayed 3 cycles per fetch -> `mem_addr` stable during each wait, bubbles (0/0) between instructions, no PC skipped.
- `br=1, br_addr=32'h0000_0103` in a cycle with a same-cycle ack at PC 8 -> that instruction is never presented, the next fetch is at 0x100, and 0x100 appears 2 cycles after `br`.
- `br` while a fetch to 0x20 is outstanding, ack 2 cycles later -> DROP discards the 0x20 data, then fetches `br_addr`. No 0x20 instruction appears on `if_*`.
- `stall` high for 4 cycles starting on an ack at PC 0x10 -> `if_*` carry bubbles for 4 cycles, then exactly one 0x10 instruction, then 0x14. `mem_req` stays low during HOLD.
- `pc` = 32'hFFFF_FFFC with an ack -> the next fetch address is 0. Asserting `rst` mid-request -> `mem_req`, `if_pc` and `if_inst` are 0 immediately.
